// File: rtl/ex_control_seq_if.sv
// EX-stage control bundle between the ID/EX register, the ALU/branch datapath and the muldiv unit.
// master drives the instruction side; slave is the control sequencer.
interface ex_control_seq_if;
  logic        instr_valid;
  logic        flush;
  logic [31:0] Instr;
  logic        BrEq;
  logic        BrLT;
  logic        BrUn;
  logic        ASel;
  logic        BSel;
  logic [3:0]  ALUSel;
  logic        PCSel;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_wb;
  logic        md_abort;
  logic        stall;
  logic        illegal;

  modport master (
    output instr_valid, flush, Instr, BrEq, BrLT,
    input  BrUn, ASel, BSel, ALUSel, PCSel, md_start, md_op, md_wb, md_abort, stall, illegal
  );

  modport slave (
    input  instr_valid, flush, Instr, BrEq, BrLT,
    output BrUn, ASel, BSel, ALUSel, PCSel, md_start, md_op, md_wb, md_abort, stall, illegal
  );
endinterface

// File: rtl/ex_control_seq.sv
// EX control: RV32I/M decode to ALU selects, branch/jump redirect, iterative muldiv stall FSM.
// Selects/PCSel/stall are combinational; illegal one cycle later; md_wb MD_CYCLES+1 cycles after md_start.
// Holds the pipeline with stall from md_start until write-back; flush aborts an in-flight muldiv.
module ex_control_seq #(
  parameter int MD_CYCLES = 32,
  parameter bit M_EXT     = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  ex_control_seq_if.slave ex
);
  localparam int              CW       = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MD_CYCLES - 1);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  md_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          md_wb_q, illegal_q;

  logic [4:0] opc;
  logic [2:0] f3;
  logic       b30;
  logic       go;
  logic       a_sel, b_sel, br_un, taken, legal, is_mop;
  logic [3:0] alu_sel;
  logic       md_start, md_abort, stall;
  logic       unused_instr;

  assign opc = ex.Instr[6:2];
  assign f3  = ex.Instr[14:12];
  assign b30 = ex.Instr[30];
  assign go  = ex.instr_valid && !ex.flush;

  assign unused_instr = ^{ex.Instr[31], ex.Instr[29:26], ex.Instr[24:15], ex.Instr[11:7], ex.Instr[1:0]};

  always_comb begin
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    alu_sel = 4'b0000;
    br_un   = 1'b0;
    taken   = 1'b0;
    legal   = 1'b0;
    is_mop  = 1'b0;
    case (opc)
      OP_REG: begin
        if (ex.Instr[25]) begin
          is_mop = M_EXT && !b30;
          legal  = is_mop;
        end else if (!b30 || f3 == 3'b000 || f3 == 3'b101) begin
          legal   = 1'b1;
          alu_sel = {b30, f3};
        end
      end
      OP_IMM: begin
        // Instr[30] is immediate data except for the shift-right pair.
        legal   = !(f3 == 3'b001 && b30);
        b_sel   = 1'b1;
        alu_sel = {b30 && (f3 == 3'b101), f3};
      end
      OP_LOAD: begin
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        b_sel = 1'b1;
      end
      OP_STORE: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        b_sel = 1'b1;
      end
      OP_JALR: begin
        legal = (f3 == 3'b000);
        b_sel = 1'b1;
        taken = 1'b1;
      end
      OP_BRANCH: begin
        legal = (f3[2:1] != 2'b01);
        a_sel = 1'b1;
        b_sel = 1'b1;
        br_un = (f3[2:1] == 2'b11);
        taken = f3[0] ^ (f3[2] ? ex.BrLT : ex.BrEq);
      end
      OP_JAL: begin
        legal = 1'b1;
        a_sel = 1'b1;
        b_sel = 1'b1;
        taken = 1'b1;
      end
      OP_AUIPC: begin
        legal = 1'b1;
        a_sel = 1'b1;
        b_sel = 1'b1;
      end
      OP_LUI: begin
        legal   = 1'b1;
        b_sel   = 1'b1;
        alu_sel = 4'b1001;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      a_sel   = 1'b0;
      b_sel   = 1'b0;
      alu_sel = 4'b0000;
      br_un   = 1'b0;
      taken   = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_start  = 1'b0;
    md_abort  = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (go && is_mop) begin
          md_start  = 1'b1;
          stall     = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (ex.flush) begin
          md_abort  = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt == '0) state_nxt = DONE;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      md_wb_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      md_wb_q   <= (state_nxt == DONE);
      illegal_q <= go && !stall && !legal;
    end
  end

  assign ex.ASel     = a_sel;
  assign ex.BSel     = b_sel;
  assign ex.ALUSel   = alu_sel;
  assign ex.BrUn     = br_un;
  assign ex.PCSel    = go && !stall && taken;
  assign ex.md_start = md_start;
  assign ex.md_op    = md_start ? f3 : 3'b000;
  assign ex.md_abort = md_abort;
  assign ex.stall    = stall;
  // A flush in the write-back cycle kills the result the held instruction would commit.
  assign ex.md_wb    = md_wb_q && !ex.flush;
  assign ex.illegal  = illegal_q;
endmodule

// File: tb/tb_ex_control_seq.sv
// Directed bench for ex_control_seq: decode table, redirects, muldiv stall timing, flush, illegal, reset.
module tb_ex_control_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_DIV  = 32'h023140B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_JALR_BAD = 32'h00009067;

  typedef struct packed {
    logic [31:0] instr;
    logic        breq;
    logic        brlt;
    logic [7:0]  exp;   // {ASel, BSel, ALUSel, BrUn, PCSel}
  } dvec_t;

  dvec_t tbl [14];

  ex_control_seq_if ifa ();
  ex_control_seq_if ifb ();

  ex_control_seq #(.MD_CYCLES(4), .M_EXT(1'b1)) u_dut     (.clk(clk), .rst_n(rst_n), .ex(ifa));
  ex_control_seq #(.MD_CYCLES(4), .M_EXT(1'b0)) u_dut_nom (.clk(clk), .rst_n(rst_n), .ex(ifb));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ifa.instr_valid = 1'b0; ifa.flush = 1'b0; ifa.Instr = '0; ifa.BrEq = 1'b0; ifa.BrLT = 1'b0;
    ifb.instr_valid = 1'b0; ifb.flush = 1'b0; ifb.Instr = '0; ifb.BrEq = 1'b0; ifb.BrLT = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if ({ifa.stall, ifa.md_start, ifa.md_abort, ifa.md_wb, ifa.illegal, ifa.PCSel} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outs: got %b want 000000",
               {ifa.stall, ifa.md_start, ifa.md_abort, ifa.md_wb, ifa.illegal, ifa.PCSel});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_decode;
    logic [7:0] got;
    tbl[0]  = '{I_ADD,        1'b0, 1'b0, 8'b0_0_0000_0_0};
    tbl[1]  = '{I_SUB,        1'b0, 1'b0, 8'b0_0_1000_0_0};
    tbl[2]  = '{32'h403150B3, 1'b0, 1'b0, 8'b0_0_1101_0_0}; // sra
    tbl[3]  = '{32'h40315093, 1'b0, 1'b0, 8'b0_1_1101_0_0}; // srai
    tbl[4]  = '{32'h40010093, 1'b0, 1'b0, 8'b0_1_0000_0_0}; // addi, imm bit 30 set
    tbl[5]  = '{32'h00313093, 1'b0, 1'b0, 8'b0_1_0011_0_0}; // sltiu
    tbl[6]  = '{32'h00012083, 1'b0, 1'b0, 8'b0_1_0000_0_0}; // lw
    tbl[7]  = '{32'h000010B7, 1'b0, 1'b0, 8'b0_1_1001_0_0}; // lui
    tbl[8]  = '{32'h00001097, 1'b0, 1'b0, 8'b1_1_0000_0_0}; // auipc
    tbl[9]  = '{32'h000000EF, 1'b0, 1'b0, 8'b1_1_0000_0_1}; // jal
    tbl[10] = '{32'h00008067, 1'b0, 1'b0, 8'b0_1_0000_0_1}; // jalr
    tbl[11] = '{32'h00208463, 1'b1, 1'b0, 8'b1_1_0000_0_1}; // beq taken
    tbl[12] = '{32'h00208463, 1'b0, 1'b1, 8'b1_1_0000_0_0}; // beq not taken
    tbl[13] = '{32'h0020D463, 1'b1, 1'b0, 8'b1_1_0000_0_1}; // bge taken
    tick;
    for (int i = 0; i < 14; i++) begin
      ifa.Instr = tbl[i].instr; ifa.BrEq = tbl[i].breq; ifa.BrLT = tbl[i].brlt; ifa.instr_valid = 1'b1;
      #1;
      got = {ifa.ASel, ifa.BSel, ifa.ALUSel, ifa.BrUn, ifa.PCSel};
      tests++;
      if (got !== tbl[i].exp) begin
        fails++;
        $display("FAIL decode[%0d] instr=%h: got %b want %b", i, tbl[i].instr, got, tbl[i].exp);
      end
      tick;
    end
    ifa.instr_valid = 1'b0; ifa.BrEq = 1'b0; ifa.BrLT = 1'b0;
  endtask

  task automatic test_bltu;
    tick;
    ifa.Instr = I_BLTU; ifa.instr_valid = 1'b1; ifa.BrLT = 1'b1;
    #1;
    tests++;
    if ({ifa.BrUn, ifa.ASel, ifa.BSel, ifa.PCSel} !== 4'b1111) begin
      fails++; $display("FAIL bltu_taken: got %b want 1111", {ifa.BrUn, ifa.ASel, ifa.BSel, ifa.PCSel});
    end
    ifa.BrLT = 1'b0;
    #1;
    tests++;
    if ({ifa.BrUn, ifa.PCSel} !== 2'b10) begin
      fails++; $display("FAIL bltu_not_taken: got %b want 10", {ifa.BrUn, ifa.PCSel});
    end
    ifa.BrLT = 1'b1; ifa.flush = 1'b1;
    #1;
    tests++;
    if (ifa.PCSel !== 1'b0) begin
      fails++; $display("FAIL bltu_flush: got PCSel=%b want 0", ifa.PCSel);
    end
    ifa.flush = 1'b0; ifa.instr_valid = 1'b0;
    #1;
    tests++;
    if (ifa.PCSel !== 1'b0) begin
      fails++; $display("FAIL bltu_invalid: got PCSel=%b want 0", ifa.PCSel);
    end
    ifa.BrLT = 1'b0;
  endtask

  task automatic test_mul_latency;
    tick;
    ifa.Instr = I_MUL; ifa.instr_valid = 1'b1;
    #1;
    tests++;
    if ({ifa.md_start, ifa.stall, ifa.md_op} !== 5'b11_000) begin
      fails++; $display("FAIL mul_launch: got %b want 11000", {ifa.md_start, ifa.stall, ifa.md_op});
    end
    for (int k = 1; k <= 4; k++) begin
      tick;
      tests++;
      if ({ifa.md_start, ifa.stall, ifa.md_wb} !== 3'b010) begin
        fails++; $display("FAIL mul_busy c%0d: got %b want 010", k, {ifa.md_start, ifa.stall, ifa.md_wb});
      end
    end
    tick;
    tests++;
    if ({ifa.md_start, ifa.stall, ifa.md_wb} !== 3'b001) begin
      fails++; $display("FAIL mul_wb: got %b want 001", {ifa.md_start, ifa.stall, ifa.md_wb});
    end
    ifa.instr_valid = 1'b0;
    tick;
    tests++;
    if ({ifa.md_start, ifa.stall, ifa.md_wb} !== 3'b000) begin
      fails++; $display("FAIL mul_after: got %b want 000", {ifa.md_start, ifa.stall, ifa.md_wb});
    end
  endtask

  task automatic test_back_to_back;
    tick;
    ifa.Instr = I_MUL; ifa.instr_valid = 1'b1;
    repeat (5) tick;
    tests++;
    if ({ifa.stall, ifa.md_wb} !== 2'b01) begin
      fails++; $display("FAIL b2b_gap: got %b want 01", {ifa.stall, ifa.md_wb});
    end
    tick;
    tests++;
    if ({ifa.md_start, ifa.stall} !== 2'b11) begin
      fails++; $display("FAIL b2b_relaunch: got %b want 11", {ifa.md_start, ifa.stall});
    end
    repeat (5) tick;
    tests++;
    if ({ifa.stall, ifa.md_wb} !== 2'b01) begin
      fails++; $display("FAIL b2b_second_wb: got %b want 01", {ifa.stall, ifa.md_wb});
    end
    ifa.instr_valid = 1'b0;
    tick;
  endtask

  task automatic test_flush_busy;
    tick;
    ifa.Instr = I_DIV; ifa.instr_valid = 1'b1;
    #1;
    tests++;
    if ({ifa.md_start, ifa.md_op} !== 4'b1_100) begin
      fails++; $display("FAIL div_launch: got %b want 1100", {ifa.md_start, ifa.md_op});
    end
    tick;
    tests++;
    if ({ifa.stall, ifa.md_abort} !== 2'b10) begin
      fails++; $display("FAIL div_busy: got %b want 10", {ifa.stall, ifa.md_abort});
    end
    tick;
    ifa.flush = 1'b1;
    #1;
    tests++;
    if ({ifa.stall, ifa.md_abort, ifa.md_wb} !== 3'b010) begin
      fails++; $display("FAIL div_abort: got %b want 010", {ifa.stall, ifa.md_abort, ifa.md_wb});
    end
    tick;
    tests++;
    if ({ifa.md_start, ifa.stall, ifa.md_abort} !== 3'b000) begin
      fails++; $display("FAIL idle_flush: got %b want 000", {ifa.md_start, ifa.stall, ifa.md_abort});
    end
    ifa.flush = 1'b0; ifa.instr_valid = 1'b0;
    for (int k = 4; k <= 9; k++) begin
      tick;
      tests++;
      if ({ifa.md_wb, ifa.stall} !== 2'b00) begin
        fails++; $display("FAIL div_no_wb c%0d: got %b want 00", k, {ifa.md_wb, ifa.stall});
      end
    end
  endtask

  task automatic test_flush_done;
    tick;
    ifa.Instr = I_MUL; ifa.instr_valid = 1'b1;
    repeat (5) tick;
    ifa.flush = 1'b1;
    #1;
    tests++;
    if ({ifa.md_wb, ifa.stall, ifa.md_abort} !== 3'b000) begin
      fails++; $display("FAIL done_flush: got %b want 000", {ifa.md_wb, ifa.stall, ifa.md_abort});
    end
    ifa.flush = 1'b0; ifa.instr_valid = 1'b0;
    tick;
  endtask

  task automatic test_illegal;
    tick;
    ifa.Instr = I_BAD; ifa.instr_valid = 1'b1;
    #1;
    tests++;
    if ({ifa.PCSel, ifa.illegal, ifa.stall} !== 3'b000) begin
      fails++; $display("FAIL bad_same_cycle: got %b want 000", {ifa.PCSel, ifa.illegal, ifa.stall});
    end
    tick;
    ifa.instr_valid = 1'b0;
    tests++;
    if (ifa.illegal !== 1'b1) begin
      fails++; $display("FAIL bad_pulse: got %b want 1", ifa.illegal);
    end
    tick;
    tests++;
    if (ifa.illegal !== 1'b0) begin
      fails++; $display("FAIL bad_pulse_end: got %b want 0", ifa.illegal);
    end
    ifa.Instr = I_JALR_BAD; ifa.instr_valid = 1'b1;
    #1;
    tests++;
    if (ifa.PCSel !== 1'b0) begin
      fails++; $display("FAIL jalr_bad_redirect: got PCSel=%b want 0", ifa.PCSel);
    end
    tick;
    ifa.Instr = I_BAD; ifa.flush = 1'b1;
    tests++;
    if (ifa.illegal !== 1'b1) begin
      fails++; $display("FAIL jalr_bad_pulse: got %b want 1", ifa.illegal);
    end
    tick;
    ifa.instr_valid = 1'b0; ifa.flush = 1'b0;
    tests++;
    if (ifa.illegal !== 1'b0) begin
      fails++; $display("FAIL bad_flushed: got %b want 0", ifa.illegal);
    end
    ifb.Instr = I_MUL; ifb.instr_valid = 1'b1;
    #1;
    tests++;
    if ({ifb.md_start, ifb.stall} !== 2'b00) begin
      fails++; $display("FAIL nom_no_start: got %b want 00", {ifb.md_start, ifb.stall});
    end
    tick;
    ifb.instr_valid = 1'b0;
    tests++;
    if ({ifb.illegal, ifb.md_start} !== 2'b10) begin
      fails++; $display("FAIL nom_illegal: got %b want 10", {ifb.illegal, ifb.md_start});
    end
    tick;
  endtask

  task automatic test_reset_busy;
    tick;
    ifa.Instr = I_MUL; ifa.instr_valid = 1'b1;
    repeat (2) tick;
    #1;
    tests++;
    if (ifa.stall !== 1'b1) begin
      fails++; $display("FAIL rst_pre_busy: got stall=%b want 1", ifa.stall);
    end
    rst_n = 1'b0; ifa.instr_valid = 1'b0;
    #1;
    tests++;
    if ({ifa.stall, ifa.md_wb, ifa.illegal, ifa.md_abort, ifa.md_start} !== 5'b0) begin
      fails++; $display("FAIL rst_async: got %b want 00000",
                        {ifa.stall, ifa.md_wb, ifa.illegal, ifa.md_abort, ifa.md_start});
    end
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    ifa.instr_valid = 1'b1;
    #1;
    tests++;
    if ({ifa.md_start, ifa.stall} !== 2'b11) begin
      fails++; $display("FAIL rst_relaunch: got %b want 11", {ifa.md_start, ifa.stall});
    end
    for (int k = 1; k <= 4; k++) begin
      tick;
      tests++;
      if ({ifa.stall, ifa.md_wb} !== 2'b10) begin
        fails++; $display("FAIL rst_busy c%0d: got %b want 10", k, {ifa.stall, ifa.md_wb});
      end
    end
    tick;
    tests++;
    if ({ifa.stall, ifa.md_wb} !== 2'b01) begin
      fails++; $display("FAIL rst_wb: got %b want 01", {ifa.stall, ifa.md_wb});
    end
    ifa.instr_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_bltu();
    test_mul_latency();
    test_back_to_back();
    test_flush_busy();
    test_flush_done();
    test_illegal();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
